debounce_pulse: RTL and testbench

- Input conditioner that sits directly upstream of the d_ff/t_ff/jk_ff storage stages.
- Takes a raw asynchronous, bouncing level (button, switch, external strobe) and passes it through a synchroniser chain.
- Debounces the level with a consecutive-sample counter, then emits a clean level plus one-cycle rise and fall pulses.
- rise_pulse connects directly to t_ff.t (one toggle per press); level_out connects to d_ff.d.

---
 rtl/debounce_pkg.sv | 15 +
 rtl/debounce_pulse_if.sv | 29 ++
 rtl/sync_chain.sv | 23 ++
 rtl/debounce_pulse.sv | 105 ++++++++++
 tb/tb_debounce_pulse.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/debounce_pkg.sv
// Shared types and default parameters for the debounce_pulse input conditioner.
package debounce_pkg;

    localparam int unsigned DEF_SYNC_STAGES     = 2;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 4;
    localparam int unsigned DEF_CNT_W           = 16;

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'b00,
        CHK_HIGH  = 2'b01,
        IDLE_HIGH = 2'b10,
        CHK_LOW   = 2'b11
    } state_t;

endpackage

// File: rtl/debounce_pulse_if.sv
// Button-side and conditioned-output signals of debounce_pulse.
interface debounce_pulse_if;

    logic btn_in;
    logic en;
    logic level_out;
    logic rise_pulse;
    logic fall_pulse;
    logic busy;

    modport master (
        output btn_in,
        output en,
        input  level_out,
        input  rise_pulse,
        input  fall_pulse,
        input  busy
    );

    modport slave (
        input  btn_in,
        input  en,
        output level_out,
        output rise_pulse,
        output fall_pulse,
        output busy
    );

endinterface

// File: rtl/sync_chain.sv
// Multi-flop synchroniser for a single asynchronous level; async reset to 0.
module sync_chain #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ff <= '0;
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/debounce_pulse.sv
// Synchronise, debounce and edge-detect a raw button level; pulses are one cycle wide.
module debounce_pulse
    import debounce_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned CNT_W           = DEF_CNT_W
) (
    input logic             clk,
    input logic             rst,
    debounce_pulse_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             s;
    logic             level_q;
    logic             rise_q;
    logic             fall_q;
    logic             busy_q;

    sync_chain #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk(clk),
        .rst(rst),
        .d  (bus.btn_in),
        .q  (s)
    );

    // Qualification FSM: a candidate level must be seen DEBOUNCE_CYCLES times in a row.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE_LOW;
            cnt     <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            case (state)
                IDLE_LOW: begin
                    if (s && bus.en) begin
                        state  <= CHK_HIGH;
                        cnt    <= CNT_ONE;
                        busy_q <= 1'b1;
                    end
                end
                CHK_HIGH: begin
                    if (!s || !bus.en) begin
                        state  <= IDLE_LOW;
                        cnt    <= '0;
                        busy_q <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        state   <= IDLE_HIGH;
                        cnt     <= '0;
                        busy_q  <= 1'b0;
                        level_q <= 1'b1;
                        rise_q  <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                IDLE_HIGH: begin
                    if (!s && bus.en) begin
                        state  <= CHK_LOW;
                        cnt    <= CNT_ONE;
                        busy_q <= 1'b1;
                    end
                end
                CHK_LOW: begin
                    if (s || !bus.en) begin
                        state  <= IDLE_HIGH;
                        cnt    <= '0;
                        busy_q <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        state   <= IDLE_LOW;
                        cnt     <= '0;
                        busy_q  <= 1'b0;
                        level_q <= 1'b0;
                        fall_q  <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state  <= IDLE_LOW;
                    cnt    <= '0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.level_out  = level_q;
    assign bus.rise_pulse = rise_q;
    assign bus.fall_pulse = fall_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_debounce_pulse.sv
// Directed bench for debounce_pulse: default instance plus a 3-stage/2-cycle instance feeding a toggle flop.
module tb_debounce_pulse;
    import debounce_pkg::*;

    logic clk;
    logic rst;
    logic tq;
    int   vecs;
    int   errs;

    debounce_pulse_if bus ();
    debounce_pulse_if bus2 ();

    debounce_pulse dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    debounce_pulse #(
        .SYNC_STAGES    (3),
        .DEBOUNCE_CYCLES(2),
        .CNT_W          (16)
    ) dut2 (
        .clk(clk),
        .rst(rst),
        .bus(bus2)
    );

    // Downstream toggle flop driven by the second instance's rise pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) tq <= 1'b0;
        else if (bus2.rise_pulse) tq <= ~tq;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.btn_in = 1'b0;
        bus.en = 1'b1;
        bus2.btn_in = 1'b0;
        bus2.en = 1'b1;
        tick();
        tick();
        vecs++; if (bus.level_out !== 1'b0) begin errs++; $display("FAIL reset_level got %b exp 0", bus.level_out); end
        vecs++; if (bus.rise_pulse !== 1'b0) begin errs++; $display("FAIL reset_rise got %b exp 0", bus.rise_pulse); end
        vecs++; if (bus.fall_pulse !== 1'b0) begin errs++; $display("FAIL reset_fall got %b exp 0", bus.fall_pulse); end
        vecs++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
        vecs++; if (bus2.level_out !== 1'b0) begin errs++; $display("FAIL reset_level2 got %b exp 0", bus2.level_out); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_glitch();
        bus.btn_in = 1'b1;
        tick(); tick(); tick();
        bus.btn_in = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            vecs++; if (bus.level_out !== 1'b0) begin errs++; $display("FAIL glitch_level edge %0d got %b exp 0", i, bus.level_out); end
            vecs++; if (bus.rise_pulse !== 1'b0 || bus.fall_pulse !== 1'b0) begin errs++; $display("FAIL glitch_pulse edge %0d got r%b f%b exp r0 f0", i, bus.rise_pulse, bus.fall_pulse); end
        end
        vecs++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL glitch_busy got %b exp 0", bus.busy); end
        vecs++; if (dut.cnt !== 16'd0) begin errs++; $display("FAIL glitch_cnt got %0d exp 0", dut.cnt); end
    endtask

    task automatic test_clean_rise();
        logic el, er, eb;
        bus.btn_in = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            el = (i >= 6);
            er = (i == 6);
            eb = (i >= 3 && i <= 5);
            vecs++; if (bus.level_out !== el) begin errs++; $display("FAIL rise_level edge %0d got %b exp %b", i, bus.level_out, el); end
            vecs++; if (bus.rise_pulse !== er) begin errs++; $display("FAIL rise_pulse edge %0d got %b exp %b", i, bus.rise_pulse, er); end
            vecs++; if (bus.fall_pulse !== 1'b0) begin errs++; $display("FAIL rise_fall edge %0d got %b exp 0", i, bus.fall_pulse); end
            vecs++; if (bus.busy !== eb) begin errs++; $display("FAIL rise_busy edge %0d got %b exp %b", i, bus.busy, eb); end
        end
    endtask

    task automatic test_bounce_fall();
        logic el, ef;
        int   nfall;
        nfall = 0;
        bus.btn_in = 1'b0;
        tick();
        bus.btn_in = 1'b1;
        tick();
        bus.btn_in = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            el = (i < 6);
            ef = (i == 6);
            if (bus.fall_pulse === 1'b1) nfall++;
            vecs++; if (bus.level_out !== el) begin errs++; $display("FAIL bounce_level edge %0d got %b exp %b", i, bus.level_out, el); end
            vecs++; if (bus.fall_pulse !== ef) begin errs++; $display("FAIL bounce_fall edge %0d got %b exp %b", i, bus.fall_pulse, ef); end
            vecs++; if (bus.rise_pulse !== 1'b0) begin errs++; $display("FAIL bounce_rise edge %0d got %b exp 0", i, bus.rise_pulse); end
        end
        vecs++; if (nfall !== 1) begin errs++; $display("FAIL bounce_count got %0d exp 1", nfall); end
    endtask

    task automatic test_enable();
        logic el;
        bus.en = 1'b0;
        bus.btn_in = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            vecs++; if (bus.level_out !== 1'b0 || bus.rise_pulse !== 1'b0 || bus.busy !== 1'b0) begin
                errs++; $display("FAIL en_hold edge %0d got l%b r%b b%b exp l0 r0 b0", i, bus.level_out, bus.rise_pulse, bus.busy);
            end
        end
        bus.en = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            el = (i >= 4);
            vecs++; if (bus.level_out !== el) begin errs++; $display("FAIL en_level edge %0d got %b exp %b", i, bus.level_out, el); end
            vecs++; if (bus.rise_pulse !== (i == 4)) begin errs++; $display("FAIL en_rise edge %0d got %b exp %b", i, bus.rise_pulse, (i == 4)); end
        end
    endtask

    task automatic test_reset_mid();
        bus.btn_in = 1'b0;
        repeat (10) tick();
        vecs++; if (bus.level_out !== 1'b0) begin errs++; $display("FAIL mid_pre_level got %b exp 0", bus.level_out); end
        bus.btn_in = 1'b1;
        repeat (4) tick();
        vecs++; if (bus.busy !== 1'b1) begin errs++; $display("FAIL mid_busy got %b exp 1", bus.busy); end
        vecs++; if (dut.cnt !== 16'd2) begin errs++; $display("FAIL mid_cnt got %0d exp 2", dut.cnt); end
        #2;
        rst = 1'b1;
        bus.btn_in = 1'b0;
        #1;
        vecs++; if (bus.busy !== 1'b0 || bus.level_out !== 1'b0 || bus.rise_pulse !== 1'b0 || bus.fall_pulse !== 1'b0) begin
            errs++; $display("FAIL mid_async got l%b r%b f%b b%b exp all 0", bus.level_out, bus.rise_pulse, bus.fall_pulse, bus.busy);
        end
        vecs++; if (dut.state !== IDLE_LOW) begin errs++; $display("FAIL mid_state got %0d exp 0", dut.state); end
        tick();
        rst = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            vecs++; if (bus.level_out !== 1'b0 || bus.rise_pulse !== 1'b0 || bus.busy !== 1'b0) begin
                errs++; $display("FAIL mid_after edge %0d got l%b r%b b%b exp l0 r0 b0", i, bus.level_out, bus.rise_pulse, bus.busy);
            end
        end
    endtask

    task automatic test_toggle();
        logic exp_q;
        exp_q = 1'b0;
        for (int p = 1; p <= 3; p++) begin
            bus2.btn_in = 1'b1;
            for (int i = 1; i <= 5; i++) begin
                tick();
                vecs++; if (bus2.level_out !== (i == 5)) begin errs++; $display("FAIL tog_level press %0d edge %0d got %b exp %b", p, i, bus2.level_out, (i == 5)); end
                vecs++; if (bus2.rise_pulse !== (i == 5)) begin errs++; $display("FAIL tog_rise press %0d edge %0d got %b exp %b", p, i, bus2.rise_pulse, (i == 5)); end
            end
            tick();
            exp_q = ~exp_q;
            vecs++; if (tq !== exp_q) begin errs++; $display("FAIL tog_q press %0d got %b exp %b", p, tq, exp_q); end
            vecs++; if (bus2.rise_pulse !== 1'b0) begin errs++; $display("FAIL tog_rise_end press %0d got %b exp 0", p, bus2.rise_pulse); end
            bus2.btn_in = 1'b0;
            repeat (8) tick();
            vecs++; if (bus2.level_out !== 1'b0) begin errs++; $display("FAIL tog_release press %0d got %b exp 0", p, bus2.level_out); end
        end
    endtask

    initial begin
        vecs = 0;
        errs = 0;
        test_reset();
        test_glitch();
        test_clean_rise();
        test_bounce_fall();
        test_enable();
        test_reset_mid();
        test_toggle();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
